// File: rtl/mema_skew_dbuf.sv
// Ping-pong A-operand tile store for the systolic MAC array.
// One bank loads from the host while the other streams out with a diagonal skew.
module mema_skew_dbuf #(
  parameter int BITS_AB = 8,
  parameter int DIM_R   = 8,
  parameter int DIM_K   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [((DIM_R > 1) ? $clog2(DIM_R) : 1)-1:0] wr_row,
  input  logic signed [DIM_K-1:0][BITS_AB-1:0] wr_data,
  input  logic                                 wr_commit,
  input  logic                                 start,
  output logic signed [DIM_R-1:0][BITS_AB-1:0] Aout,
  output logic [DIM_R-1:0]                     Avld,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 ready,
  output logic                                 wr_drop
);

  localparam int T  = DIM_K + DIM_R - 1;
  localparam int TW = $clog2(T + 1);
  localparam int RW = (DIM_R > 1) ? $clog2(DIM_R) : 1;
  localparam int KW = (DIM_K > 1) ? $clog2(DIM_K) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(T - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_n;
  logic [TW-1:0] t, t_n;
  logic load_sel, stream_sel_n;
  logic wr_ok, drop_n, accept, ready_n;
  logic [DIM_R-1:0][BITS_AB-1:0] aout_n;
  logic [DIM_R-1:0] vld_n;

  logic [BITS_AB-1:0] mem [2][DIM_R][DIM_K];

  always_comb begin
    wr_ok  = wr_en && !ready && (int'(wr_row) < DIM_R);
    drop_n = (wr_en && !wr_ok) || (wr_commit && ready);
    // done doubles as the back-to-back window so a new tile follows with no bubble
    accept = start && ready && ((state == IDLE) || done);
    ready_n = accept ? 1'b0 : (ready || wr_commit);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < DIM_K; k++) begin
        mem[load_sel][wr_row][k] <= wr_data[k];
      end
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    if (accept) begin
      state_n = STREAM;
      t_n     = '0;
    end else if (state == STREAM) begin
      if (t == T_LAST) begin
        state_n = IDLE;
        t_n     = '0;
      end else begin
        t_n = t + 1'b1;
      end
    end
  end

  // Outputs are registered, so lane data is looked up for the step about to be shown.
  always_comb begin
    stream_sel_n = accept ? load_sel : ~load_sel;
    aout_n = '0;
    vld_n  = '0;
    for (int i = 0; i < DIM_R; i++) begin
      int k;
      k = int'(t_n) - i;
      if ((state_n == STREAM) && (k >= 0) && (k < DIM_K)) begin
        aout_n[i[RW-1:0]] = mem[stream_sel_n][i[RW-1:0]][k[KW-1:0]];
        vld_n[i[RW-1:0]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      load_sel <= 1'b0;
      ready    <= 1'b0;
      Aout     <= '0;
      Avld     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_n;
      t        <= t_n;
      if (accept) load_sel <= ~load_sel;
      ready    <= ready_n;
      Aout     <= aout_n;
      Avld     <= vld_n;
      busy     <= (state_n == STREAM);
      done     <= (state_n == STREAM) && (t_n == T_LAST);
      wr_drop  <= drop_n;
    end
  end

endmodule

// File: tb/tb_mema_skew_dbuf.sv
// Bench for mema_skew_dbuf: a 4x4 instance for streaming, ping-pong, rejects and reset,
// and a 3x5 instance for the non-square skew and out-of-range row writes.
module tb_mema_skew_dbuf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wr_en = 1'b0, wr_commit = 1'b0, start = 1'b0;
  logic [1:0] wr_row = '0;
  logic signed [3:0][7:0] wr_data = '0;
  logic signed [3:0][7:0] aout;
  logic [3:0] avld;
  logic busy, done, ready, wr_drop;

  logic b_wr_en = 1'b0, b_wr_commit = 1'b0, b_start = 1'b0;
  logic [1:0] b_wr_row = '0;
  logic signed [4:0][7:0] b_wr_data = '0;
  logic signed [2:0][7:0] b_aout;
  logic [2:0] b_avld;
  logic b_busy, b_done, b_ready, b_wr_drop;

  mema_skew_dbuf #(.BITS_AB(8), .DIM_R(4), .DIM_K(4)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .start(start), .Aout(aout), .Avld(avld), .busy(busy),
    .done(done), .ready(ready), .wr_drop(wr_drop)
  );

  mema_skew_dbuf #(.BITS_AB(8), .DIM_R(3), .DIM_K(5)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data),
    .wr_commit(b_wr_commit), .start(b_start), .Aout(b_aout), .Avld(b_avld), .busy(b_busy),
    .done(b_done), .ready(b_ready), .wr_drop(b_wr_drop)
  );

  typedef struct {
    logic [3:0][7:0] aout;
    logic [3:0]      avld;
    logic            busy;
    logic            done;
  } exp_t;

  typedef struct {
    logic       wr_en;
    logic [1:0] row;
    logic [7:0] fill;
    logic       commit;
    logic       start;
    logic       exp_drop;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  vec_t vecs[6];
  logic [7:0] tile_buf [2][4][5];
  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillTile(input int slot, input int base, input int nk);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 5; k++)
        tile_buf[slot][i][k] = 8'(base + nk * i + k + 1);
  endtask

  // Expected stream: lane i shows element t-i of its row while that index is in range.
  task automatic pushTile(input int which, input int slot, input int nr, input int nk);
    exp_t e;
    int tt;
    tt = nk + nr - 1;
    for (int t = 0; t < tt; t++) begin
      e.aout = '0;
      e.avld = '0;
      e.busy = 1'b1;
      e.done = (t == tt - 1);
      for (int i = 0; i < nr; i++) begin
        int k;
        k = t - i;
        if (k >= 0 && k < nk) begin
          e.aout[i] = tile_buf[slot][i][k];
          e.avld[i] = 1'b1;
        end
      end
      if (which == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic writeRow(input int slot, input int row, input logic commit);
    wr_en = 1'b1;
    wr_row = 2'(row);
    for (int k = 0; k < 4; k++) wr_data[k] = tile_buf[slot][row][k];
    wr_commit = commit;
    tick();
    wr_en = 1'b0;
    wr_commit = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    wr_en = v.wr_en;
    wr_row = v.row;
    wr_data = {4{v.fill}};
    wr_commit = v.commit;
    start = v.start;
    tick();
    wr_en = 1'b0;
    wr_commit = 1'b0;
    start = 1'b0;
    checkOutput($sformatf("vec%0d_wr_drop", idx), wr_drop, v.exp_drop);
    checkOutput($sformatf("vec%0d_ready", idx), ready, v.exp_ready);
    checkOutput($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
  endtask

  // Each falling edge compares against the next expected stream step, or the idle state.
  always @(negedge clk) begin
    if (rst_n) begin
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        checkOutput("a_Aout", aout, ea.aout);
        checkOutput("a_Avld", avld, ea.avld);
        checkOutput("a_busy", busy, ea.busy);
        checkOutput("a_done", done, ea.done);
      end else begin
        checkOutput("a_idle_busy", busy, 0);
        checkOutput("a_idle_Avld", avld, 0);
        checkOutput("a_idle_done", done, 0);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        checkOutput("b_Aout", {8'h00, b_aout}, eb.aout);
        checkOutput("b_Avld", {1'b0, b_avld}, eb.avld);
        checkOutput("b_busy", b_busy, eb.busy);
        checkOutput("b_done", b_done, eb.done);
      end else begin
        checkOutput("b_idle_busy", b_busy, 0);
        checkOutput("b_idle_Avld", b_avld, 0);
        checkOutput("b_idle_done", b_done, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    #1;
    checkOutput("rst_Aout", aout, 0);
    checkOutput("rst_Avld", avld, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_wr_drop", wr_drop, 0);
    checkOutput("rst_b_ready", b_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single tile, then tile 2 loaded during streaming and started in the done cycle
    fillTile(0, 0, 4);
    fillTile(1, 100, 4);
    for (int r = 0; r < 4; r++) writeRow(0, r, 1'b0);
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    checkOutput("ready_after_commit", ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    pushTile(0, 0, 4, 4);
    for (int r = 0; r < 4; r++) writeRow(1, r, 1'b0);
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    checkOutput("ready_tile2", ready, 1);
    checkOutput("busy_mid_stream", busy, 1);
    start = 1'b1;
    tick();
    checkOutput("start_before_done_ignored", ready, 1);
    tick();
    start = 1'b0;
    pushTile(0, 1, 4, 4);
    checkOutput("ready_cleared_on_accept", ready, 0);
    repeat (9) tick();

    // Rejects and start gating, then stream the tile to show row 2 kept its contents
    fillTile(0, 32, 4);
    for (int r = 0; r < 4; r++) writeRow(0, r, 1'b0);
    for (int v = 0; v < 6; v++) applyStimulus(vecs[v], v);
    for (int k = 0; k < 4; k++) tile_buf[0][0][k] = 8'h50;
    start = 1'b1;
    tick();
    start = 1'b0;
    pushTile(0, 0, 4, 4);
    repeat (9) tick();

    // Async reset in the middle of a stream with the other bank already committed
    fillTile(1, 60, 4);
    for (int r = 0; r < 3; r++) writeRow(1, r, 1'b0);
    writeRow(1, 3, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    pushTile(0, 1, 4, 4);
    fillTile(0, 200, 4);
    writeRow(0, 0, 1'b1);
    tick();
    tick();
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_ready", ready, 1);
    qa.delete();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_Aout", aout, 0);
    checkOutput("async_rst_Avld", avld, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_ready", ready, 0);
    checkOutput("async_rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    fillTile(0, 80, 4);
    for (int r = 0; r < 4; r++) writeRow(0, r, 1'b0);
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pushTile(0, 0, 4, 4);
    repeat (9) tick();

    // Non-square 3x5 instance
    fillTile(1, 0, 5);
    for (int r = 0; r < 3; r++) begin
      b_wr_en = 1'b1;
      b_wr_row = 2'(r);
      for (int k = 0; k < 5; k++) b_wr_data[k] = tile_buf[1][r][k];
      tick();
      b_wr_en = 1'b0;
    end
    b_wr_en = 1'b1;
    b_wr_row = 2'd3;
    b_wr_data = {5{8'hEE}};
    tick();
    b_wr_en = 1'b0;
    checkOutput("b_drop_row3", b_wr_drop, 1);
    checkOutput("b_ready_after_bad_row", b_ready, 0);
    tick();
    checkOutput("b_drop_pulse_end", b_wr_drop, 0);
    b_wr_commit = 1'b1;
    tick();
    b_wr_commit = 1'b0;
    checkOutput("b_ready", b_ready, 1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    pushTile(1, 1, 3, 5);
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
